// File: rtl/m68k_bus_master_pkg.sv
// ============================================================================
// Module      : m68k_bus_pkg
// Description : Shared state encoding and bus constants for the 68030-style
//               bus initiator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package m68k_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR    = 3'd1,
        ST_STROBE  = 3'd2,
        ST_WAIT    = 3'd3,
        ST_TERM    = 3'd4,
        ST_RECOVER = 3'd5
    } bus_state_t;

    localparam logic [1:0] SIZ_BYTE = 2'b01;
    localparam logic [1:0] SIZ_WORD = 2'b10;
    localparam logic [1:0] SIZ_LONG = 2'b00;

    localparam logic [2:0] FC_USER_DATA = 3'b001;
    localparam logic [2:0] FC_SUPV_DATA = 3'b101;
    localparam logic [2:0] FC_CPU_SPACE = 3'b111;

endpackage

`default_nettype wire

// File: rtl/m68k_bus_master_if.sv
// ============================================================================
// Module      : m68k_bus_master_if
// Description : Request/response side and 68030 bus side of the initiator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface m68k_bus_master_if;
    logic        req;
    logic [31:0] req_addr;
    logic        req_wr;
    logic [7:0]  req_wdata;
    logic [2:0]  req_fc;
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0]  rdata;
    logic [31:0] a;
    logic [2:0]  fc;
    logic        rw;
    logic [1:0]  siz;
    logic        as_n;
    logic        ds_n;
    logic [7:0]  d_out;
    logic        d_oe;
    logic [7:0]  d_in;
    logic        dsack0_n;
    logic        dsack1_n;
    logic        berr_n;

    modport master (
        input  req, req_addr, req_wr, req_wdata, req_fc,
        input  d_in, dsack0_n, dsack1_n, berr_n,
        output busy, done, err, rdata,
        output a, fc, rw, siz, as_n, ds_n, d_out, d_oe
    );

    modport slave (
        output req, req_addr, req_wr, req_wdata, req_fc,
        output d_in, dsack0_n, dsack1_n, berr_n,
        input  busy, done, err, rdata,
        input  a, fc, rw, siz, as_n, ds_n, d_out, d_oe
    );
endinterface

`default_nettype wire

// File: rtl/m68k_bus_master_input_sync.sv
// ============================================================================
// Module      : bus_input_sync
// Description : Multi-bit flop-chain synchronizer, flops reset to 1 so that
//               active-low bus terminations start negated.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_input_sync #(
    parameter int WIDTH  = 3,
    parameter int STAGES = 2
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic [WIDTH-1:0] i_async,
    output logic      [WIDTH-1:0] o_sync
);

    logic [WIDTH-1:0] r_chain [STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                r_chain[i] <= '1;
            end
        end else begin
            r_chain[0] <= i_async;
            for (int i = 1; i < STAGES; i++) begin
                r_chain[i] <= r_chain[i-1];
            end
        end
    end

    assign o_sync = r_chain[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/m68k_bus_master.sv
// ============================================================================
// Module      : m68k_bus_master
// Description : Single-byte 68030-style asynchronous bus cycle initiator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module m68k_bus_master
    import m68k_bus_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input wire logic          clk,
    input wire logic          rst,
    m68k_bus_master_if.master bus
);

    localparam logic [15:0] c_timeout_last = 16'(TIMEOUT_CYCLES - 1);

    bus_state_t  r_state;
    bus_state_t  w_next;
    logic [31:0] r_a;
    logic [2:0]  r_fc;
    logic        r_rw;
    logic [7:0]  r_d_out;
    logic [7:0]  r_rdata;
    logic        r_err;
    logic [15:0] r_cnt;

    logic [2:0]  w_sync;
    logic        w_ack;
    logic        w_berr;
    logic        w_timeout;

    bus_input_sync #(
        .WIDTH  (3),
        .STAGES (SYNC_STAGES)
    ) u_term_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async ({bus.berr_n, bus.dsack1_n, bus.dsack0_n}),
        .o_sync  (w_sync)
    );

    assign w_ack     = ~w_sync[0] | ~w_sync[1];
    assign w_berr    = ~w_sync[2];
    assign w_timeout = (r_cnt == c_timeout_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (bus.req) w_next = ST_ADDR;
            ST_ADDR:    w_next = ST_STROBE;
            ST_STROBE:  w_next = ST_WAIT;
            ST_WAIT:    if (w_berr || w_ack || w_timeout) w_next = ST_TERM;
            ST_TERM:    w_next = ST_RECOVER;
            // One clock here already satisfies the minimum recovery; a
            // responder with DSACK tied low must not stall us, so only a
            // still-asserted BERR holds the block in RECOVER.
            ST_RECOVER: if (!w_berr) w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_fc    <= '0;
            r_rw    <= 1'b1;
            r_d_out <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            if (r_state == ST_IDLE && bus.req) begin
                r_a     <= bus.req_addr;
                r_fc    <= bus.req_fc;
                r_rw    <= ~bus.req_wr;
                r_d_out <= bus.req_wdata;
                r_err   <= 1'b0;
            end
            if (r_state == ST_WAIT && w_next == ST_WAIT) begin
                r_cnt <= r_cnt + 16'd1;
            end else begin
                r_cnt <= '0;
            end
            if (r_state == ST_WAIT) begin
                if (w_berr) begin
                    r_err <= 1'b1;
                end else if (w_ack) begin
                    r_err <= 1'b0;
                    if (r_rw) r_rdata <= bus.d_in;
                end else if (w_timeout) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    logic w_as_n;
    logic w_ds_n;
    logic w_d_oe;
    logic w_busy;
    logic w_done;
    logic w_err;

    always_comb begin
        w_as_n = 1'b1;
        w_ds_n = 1'b1;
        w_d_oe = 1'b0;
        w_busy = (r_state != ST_IDLE);
        w_done = 1'b0;
        w_err  = 1'b0;
        case (r_state)
            ST_ADDR: begin
                w_d_oe = ~r_rw;
            end
            ST_STROBE: begin
                w_as_n = 1'b0;
                w_ds_n = ~r_rw;   // writes hold DS_n off for data setup
                w_d_oe = ~r_rw;
            end
            ST_WAIT: begin
                w_as_n = 1'b0;
                w_ds_n = 1'b0;
                w_d_oe = ~r_rw;
            end
            ST_TERM: begin
                w_done = 1'b1;
                w_err  = r_err;
            end
            default: ;
        endcase
    end

    assign bus.as_n  = w_as_n;
    assign bus.ds_n  = w_ds_n;
    assign bus.d_oe  = w_d_oe;
    assign bus.busy  = w_busy;
    assign bus.done  = w_done;
    assign bus.err   = w_err;
    assign bus.a     = r_a;
    assign bus.fc    = r_fc;
    assign bus.rw    = r_rw;
    assign bus.siz   = SIZ_BYTE;
    assign bus.d_out = r_d_out;
    assign bus.rdata = r_rdata;

endmodule

`default_nettype wire
